tile_xfer_sched: RTL
====================

TILE_XFER_SCHED -- requirements
Module: tile_xfer_sched

Interface
REQ-001 SHALL have parameter AW, 12, internal memory address width (tile length width).
REQ-002 SHALL have parameter DW, 32, data/address width in bits.
REQ-003 SHALL have parameter DATA_SIZE, 1024, total words per task.
REQ-004 SHALL have parameter TILE_SIZE, 128, maximum words per tile; 1 <= TILE_SIZE <= 2^AW-1.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port config_done  input  1  one-cycle pulse; starts a task.
REQ-008 SHALL have port param_raddr  input  DW  byte base address of source data.
REQ-009 SHALL have port param_waddr  input  DW  byte base address of destination.
REQ-010 SHALL have port load_data_start  output  1  one-cycle pulse; starts a tile load.
REQ-011 SHALL have port load_data_done  input  1  one-cycle pulse; tile load complete.
REQ-012 SHALL have port store_data_start  output  1  one-cycle pulse; starts a tile store.
REQ-013 SHALL have port store_data_done  input  1  one-cycle pulse; tile store complete.
REQ-014 SHALL have port tile_raddr  output  DW  byte read address of current tile.
REQ-015 SHALL have port tile_waddr  output  DW  byte write address of current tile.
REQ-016 SHALL have port tile_len  output  AW  word count of current tile.
REQ-017 SHALL have port tile_idx  output  16  zero-based index of current tile.
REQ-018 SHALL have port busy  output  1  high from first cycle after accepted config_done until task_done.
REQ-019 SHALL have port task_done  output  1  one-cycle pulse; all tiles stored.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, LOAD_WAIT, STORE, STORE_WAIT, NEXT, DONE; all outputs registered.
REQ-021 SHALL compute NTILE = ceil(DATA_SIZE/TILE_SIZE) and LAST_LEN = DATA_SIZE - (NTILE-1)*TILE_SIZE at elaboration.
REQ-022 IDLE: config_done sampled high -> latch param_raddr/param_waddr into tile_raddr/tile_waddr, tile_idx=0, tile_len=(NTILE==1 ? LAST_LEN : TILE_SIZE), busy=1, go LOAD.
REQ-023 LOAD: load_data_start high for exactly this one cycle (cycle N+1 after config_done at N); go LOAD_WAIT.
REQ-024 LOAD_WAIT: hold until load_data_done sampled high, then go STORE; store_data_start high exactly one cycle in STORE; go STORE_WAIT.
REQ-025 STORE_WAIT: on store_data_done, go DONE if tile_idx==NTILE-1, else NEXT.
REQ-026 NEXT (one cycle): tile_idx+1, tile_raddr and tile_waddr += TILE_SIZE*(DW/8) modulo 2^DW, tile_len = LAST_LEN if new index is NTILE-1 else TILE_SIZE; go LOAD.
REQ-027 DONE: task_done high for exactly one cycle, busy cleared in same cycle, go IDLE.
REQ-028 tile_raddr, tile_waddr, tile_len, tile_idx SHALL remain stable from LOAD through STORE_WAIT of each tile.
REQ-029 config_done while busy SHALL be ignored (no relatch, no restart).
REQ-030 load_data_done outside LOAD_WAIT and store_data_done outside STORE_WAIT SHALL be ignored.
REQ-031 load_data_start and store_data_start SHALL never be high in the same cycle.
REQ-032 config_done in the cycle DONE returns to IDLE SHALL be ignored; next task needs config_done sampled in IDLE.

Reset
REQ-033 rst high at any edge, including mid-task, SHALL force IDLE and clear load_data_start, store_data_start, busy, task_done, tile_idx, tile_len, tile_raddr, tile_waddr to 0 in the next cycle.
REQ-034 After reset, no output pulse SHALL occur until a new config_done is sampled in IDLE.

Verification
REQ-035 DATA_SIZE=1024, TILE_SIZE=128, raddr=0x1000, waddr=0x8000, done pulses 5 cycles after each start -> 8 load/store pairs, tile_raddr 0x1000..0x1E00 step 0x200, tile_len=128 each, single task_done after 8th store_data_done.
REQ-036 DATA_SIZE=300, TILE_SIZE=128 -> 3 tiles, tile_len 128,128,44; task_done one cycle after 3rd store_data_done.
REQ-037 config_done at cycle N -> load_data_start at N+1 only; load_data_done at M -> store_data_start at M+1 only.
REQ-038 Extra config_done during LOAD_WAIT and spurious store_data_done during LOAD_WAIT -> no relatch, no state change, tile_idx unchanged.
REQ-039 rst asserted during STORE_WAIT of tile 3 -> all outputs 0 next cycle; fresh config_done restarts at tile_idx 0 with new base addresses.
REQ-040 raddr=0xFFFFFF00, TILE_SIZE=128, DATA_SIZE=256 -> second tile_raddr wraps to 0x00000100.

Source files
------------

// File: rtl/tile_xfer_sched.sv
// Tile transfer scheduler: splits a DATA_SIZE-word task into TILE_SIZE-word
// tiles and sequences one load/store handshake pair per tile.
module tile_xfer_sched #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int DATA_SIZE = 1024,
  parameter int TILE_SIZE = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          config_done,
  input  logic [DW-1:0] param_raddr,
  input  logic [DW-1:0] param_waddr,
  output logic          load_data_start,
  input  logic          load_data_done,
  output logic          store_data_start,
  input  logic          store_data_done,
  output logic [DW-1:0] tile_raddr,
  output logic [DW-1:0] tile_waddr,
  output logic [AW-1:0] tile_len,
  output logic [15:0]   tile_idx,
  output logic          busy,
  output logic          task_done,
  output logic [2:0]    fsm_state
);

  localparam int NTILE    = (DATA_SIZE + TILE_SIZE - 1) / TILE_SIZE;
  localparam int LAST_LEN = DATA_SIZE - (NTILE - 1) * TILE_SIZE;

  localparam logic [15:0]   LAST_IDX = 16'(NTILE - 1);
  localparam logic [AW-1:0] FULL_LEN = AW'(TILE_SIZE);
  localparam logic [AW-1:0] TAIL_LEN = AW'(LAST_LEN);
  localparam logic [DW-1:0] STEP     = DW'(TILE_SIZE * (DW / 8));

  // Handshakes: each *_start is a one-cycle request; the matching *_done
  // pulse is honoured only in the corresponding *_WAIT state, never buffered.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_LOAD_WAIT  = 3'd2,
    S_STORE      = 3'd3,
    S_STORE_WAIT = 3'd4,
    S_NEXT       = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t state, state_d;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:       if (config_done) state_d = S_LOAD;
      S_LOAD:       state_d = S_LOAD_WAIT;
      S_LOAD_WAIT:  if (load_data_done) state_d = S_STORE;
      S_STORE:      state_d = S_STORE_WAIT;
      S_STORE_WAIT: if (store_data_done)
                      state_d = (tile_idx == LAST_IDX) ? S_DONE : S_NEXT;
      S_NEXT:       state_d = S_LOAD;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Pulses are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data_start  <= 1'b0;
      store_data_start <= 1'b0;
      busy             <= 1'b0;
      task_done        <= 1'b0;
      tile_idx         <= '0;
      tile_len         <= '0;
      tile_raddr       <= '0;
      tile_waddr       <= '0;
    end else begin
      load_data_start  <= (state_d == S_LOAD);
      store_data_start <= (state_d == S_STORE);
      busy             <= (state_d != S_IDLE) && (state_d != S_DONE);
      task_done        <= (state_d == S_DONE);
      if (state == S_IDLE && config_done) begin
        tile_raddr <= param_raddr;
        tile_waddr <= param_waddr;
        tile_idx   <= '0;
        tile_len   <= (NTILE == 1) ? TAIL_LEN : FULL_LEN;
      end else if (state == S_NEXT) begin
        tile_raddr <= tile_raddr + STEP;
        tile_waddr <= tile_waddr + STEP;
        tile_idx   <= tile_idx + 16'd1;
        tile_len   <= ((tile_idx + 16'd1) == LAST_IDX) ? TAIL_LEN : FULL_LEN;
      end
    end
  end

endmodule
